stream_demux_reg: RTL and testbench

- Parametrised, registered 1-to-NCH demultiplexer for valid/ready streams; the sequential successor to the team's combinational 1-to-4 decoder.
- Steers each input beat to one output channel selected by in_sel, or to all channels when in_bcast is set.
- Each channel has a one-entry output register with independent backpressure.
- Out-of-range selects are dropped and recorded in status outputs.
- Sits between a single producer and NCH downstream consumers.

---
 rtl/stream_demux_reg.sv | 95 +++++++++
 tb/tb_stream_demux_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_reg.sv
// Registered 1-to-NCH demultiplexer for valid/ready streams with unicast,
// broadcast and drop-on-bad-select handling; one output register per channel.
module stream_demux_reg #(
    parameter int unsigned DW  = 8,
    parameter int unsigned NCH = 4,
    parameter int unsigned SW  = 2,
    parameter int unsigned CW  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [SW-1:0]       in_sel,
    input  logic                in_bcast,
    output logic [NCH-1:0]      out_valid,
    input  logic [NCH-1:0]      out_ready,
    output logic [NCH*DW-1:0]   out_data,
    input  logic                err_clr,
    output logic                err_sel,
    output logic [CW-1:0]       drop_cnt
);

    if ((2 ** SW) < NCH || NCH < 2 || NCH > 16) begin : g_bad_params
        $error("stream_demux_reg: need 2 <= NCH <= 16 and 2**SW >= NCH");
    end

    logic [NCH-1:0] free;
    logic [NCH-1:0] sel_oh;
    logic [NCH-1:0] load;
    logic           drop;

    assign free = ~out_valid | out_ready;

    // One-hot decode of in_sel; all-zero means the select is out of range
    always_comb begin
        sel_oh = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (in_sel == SW'(k)) begin
                sel_oh[k] = 1'b1;
            end
        end
    end

    // Input handshake and per-channel load strobes
    always_comb begin
        in_ready = 1'b0;
        load     = '0;
        drop     = 1'b0;
        if (in_bcast) begin
            in_ready = &free;
            load     = {NCH{in_valid & (&free)}};
        end else if (|sel_oh) begin
            in_ready = |(sel_oh & free);
            load     = sel_oh & free & {NCH{in_valid}};
        end else begin
            in_ready = 1'b1;
            drop     = in_valid;
        end
    end

    // Channel registers: a load wins over a drain in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    out_valid[k]            <= 1'b1;
                    out_data[k*DW +: DW]    <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k]            <= 1'b0;
                end
            end
        end
    end

    // Drop status; clear takes priority over a simultaneous drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else if (err_clr) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err_sel  <= 1'b1;
            if (drop_cnt != {CW{1'b1}}) begin
                drop_cnt <= drop_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_reg.sv
// Bench for stream_demux_reg: directed vector table on a 4-channel instance,
// drop/saturation sequence on a 3-channel instance, scoreboard on an 8-channel one.
module tb_stream_demux_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults (DW=8, NCH=4, SW=2)
    logic        a_valid, a_ready, a_bcast, a_clr, a_err;
    logic [7:0]  a_data, a_cnt;
    logic [1:0]  a_sel;
    logic [3:0]  a_ov, a_ordy;
    logic [31:0] a_od;

    stream_demux_reg u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
        .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
        .err_clr(a_clr), .err_sel(a_err), .drop_cnt(a_cnt)
    );

    // Instance B: NCH=3 so that select 3 is out of range
    logic        b_valid, b_ready, b_bcast, b_clr, b_err;
    logic [7:0]  b_data, b_cnt;
    logic [1:0]  b_sel;
    logic [2:0]  b_ov, b_ordy;
    logic [23:0] b_od;

    stream_demux_reg #(.DW(8), .NCH(3), .SW(2), .CW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
        .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
        .err_clr(b_clr), .err_sel(b_err), .drop_cnt(b_cnt)
    );

    // Instance C: wide regression configuration
    logic         c_valid, c_ready, c_bcast, c_clr, c_err;
    logic [15:0]  c_data;
    logic [7:0]   c_cnt;
    logic [2:0]   c_sel;
    logic [7:0]   c_ov, c_ordy;
    logic [127:0] c_od;

    stream_demux_reg #(.DW(16), .NCH(8), .SW(3), .CW(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
        .in_data(c_data), .in_sel(c_sel), .in_bcast(c_bcast),
        .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od),
        .err_clr(c_clr), .err_sel(c_err), .drop_cnt(c_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        bc;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        rdy;
        logic [3:0]  ov;
        logic [31:0] od;
    } vec_t;

    vec_t vecs [15];

    // Scoreboard for instance C: per-channel FIFO of expected beats
    logic [15:0] sb [8][2048];
    int          wr [8];
    int          rd [8];

    task automatic c_step();
        logic [7:0] fr;
        #1;
        fr = ~c_ov | c_ordy;
        chk("c_in_ready", 128'(c_ready), 128'(c_bcast ? (&fr) : fr[c_sel]));
        for (int k = 0; k < 8; k++) begin
            if (c_ov[k]) begin
                chk("c_valid_has_beat", 128'(rd[k] != wr[k]), 128'(1));
                if (rd[k] != wr[k]) begin
                    chk("c_data", 128'(c_od[k*16 +: 16]), 128'(sb[k][rd[k]]));
                    if (c_ordy[k]) rd[k]++;
                end
            end
        end
        if (c_valid && c_ready) begin
            for (int k = 0; k < 8; k++) begin
                if (c_bcast || c_sel == 3'(k)) begin
                    if (wr[k] < 2048) begin
                        sb[k][wr[k]] = c_data;
                        wr[k]++;
                    end
                end
            end
        end
    endtask

    initial begin
        logic [31:0] mask;

        rst_n = 1'b0;
        a_valid = 0; a_bcast = 0; a_clr = 0; a_data = 0; a_sel = 0; a_ordy = 0;
        b_valid = 0; b_bcast = 0; b_clr = 0; b_data = 0; b_sel = 0; b_ordy = 0;
        c_valid = 0; c_bcast = 0; c_clr = 0; c_data = 0; c_sel = 0; c_ordy = 0;
        for (int k = 0; k < 8; k++) begin wr[k] = 0; rd[k] = 0; end

        // Reset behaviour
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ov", 128'(a_ov), 128'(0));
        chk("idle_cnt", 128'(b_cnt), 128'(0));
        @(negedge clk);
        a_valid = 1; a_sel = 0; a_data = 8'hFF; a_ordy = 4'h0;
        b_valid = 1; b_sel = 2'd3;
        @(posedge clk); #1;
        chk("pre_rst_ov", 128'(a_ov), 128'(4'b0001));
        chk("pre_rst_cnt", 128'(b_cnt), 128'(1));
        a_valid = 0; b_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ov", 128'(a_ov), 128'(0));
        chk("async_rst_od", 128'(a_od), 128'(0));
        chk("async_rst_cnt", 128'(b_cnt), 128'(0));
        chk("async_rst_err", 128'(b_err), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_ov", 128'(a_ov), 128'(0));
        chk("post_rst_cnt", 128'(b_cnt), 128'(0));

        // Directed vectors: unicast sweep, backpressure, broadcast
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A100};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A20000};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3000000};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 8'h11, 4'hB, 1'b1, 4'b0100, 32'h00110000};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'hB, 1'b0, 4'b0100, 32'h00110000};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'hF, 1'b1, 4'b0100, 32'h00220000};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 8'h44, 4'hB, 1'b1, 4'b0110, 32'h00224400};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};
        vecs[10] = '{1'b1, 2'd0, 1'b1, 8'h5A, 4'hF, 1'b1, 4'b1111, 32'h5A5A5A5A};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'h7, 1'b1, 4'b1000, 32'h5A000000};
        vecs[12] = '{1'b1, 2'd0, 1'b1, 8'h66, 4'h7, 1'b0, 4'b1000, 32'h5A000000};
        vecs[13] = '{1'b1, 2'd0, 1'b1, 8'h66, 4'hF, 1'b1, 4'b1111, 32'h66666666};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a_valid = vecs[i].v;  a_sel  = vecs[i].sel; a_bcast = vecs[i].bc;
            a_data  = vecs[i].d;  a_ordy = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 128'(a_ready), 128'(vecs[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 128'(a_ov), 128'(vecs[i].ov));
            for (int k = 0; k < 4; k++) mask[k*8 +: 8] = {8{vecs[i].ov[k]}};
            chk($sformatf("vec%0d_out_data", i), 128'(a_od & mask), 128'(vecs[i].od & mask));
        end
        @(negedge clk);
        a_valid = 0; a_bcast = 0;

        // Out-of-range drops and counter saturation
        b_valid = 1; b_sel = 2'd3; b_ordy = 3'b111; b_data = 8'h12;
        #1;
        chk("drop_in_ready", 128'(b_ready), 128'(1));
        @(posedge clk); #1;
        chk("drop_no_ov", 128'(b_ov), 128'(0));
        chk("drop_err", 128'(b_err), 128'(1));
        chk("drop_cnt1", 128'(b_cnt), 128'(1));
        repeat (299) @(posedge clk);
        #1;
        chk("drop_cnt_sat", 128'(b_cnt), 128'(255));
        chk("drop_err_sticky", 128'(b_err), 128'(1));
        @(negedge clk);
        b_clr = 1;
        @(posedge clk); #1;
        chk("clr_err", 128'(b_err), 128'(0));
        chk("clr_cnt", 128'(b_cnt), 128'(0));
        @(negedge clk);
        b_clr = 0; b_valid = 0;
        @(posedge clk); #1;
        chk("clr_idle_cnt", 128'(b_cnt), 128'(0));

        // Random regression with per-channel scoreboard
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            c_valid = ($urandom_range(0, 3) != 0);
            c_bcast = ($urandom_range(0, 7) == 0);
            c_sel   = 3'($urandom_range(0, 7));
            c_data  = 16'($urandom);
            c_ordy  = 8'($urandom) | 8'($urandom);
            c_step();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c_valid = 0; c_ordy = 8'hFF;
            c_step();
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("c_ch%0d_all_delivered", k), 128'(wr[k] - rd[k]), 128'(0));
        end
        chk("c_no_drops", 128'(c_cnt), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
